// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: operator codes, default widths
// and the round-robin port type.
package alu_pkg;

    localparam int ALU_D_WIDTH  = 32;
    localparam int ALU_OP_WIDTH = 4;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

endpackage

// File: rtl/alu_rsp_slot.sv
// Single-entry response holding register (result + zero flag) with a
// valid/ready interface toward the requester.
module alu_rsp_slot
    import alu_pkg::*;
#(
    parameter int D_WIDTH = ALU_D_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [D_WIDTH-1:0] load_data,
    input  logic               load_zero,
    input  logic               rsp_ready,
    output logic               free,
    output logic               rsp_valid,
    output logic [D_WIDTH-1:0] rsp_data,
    output logic               rsp_zero
);

    // A slot being drained this cycle may accept a new result on the same edge.
    assign free = ~rsp_valid | rsp_ready;

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values; the data register is reset because it is visible on a port.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
        end else if (load) begin
            rsp_valid <= 1'b1;
            rsp_data  <= load_data;
            rsp_zero  <= load_zero;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional grant/conflict counters are enabled with ALU_ARB_STATS_EN.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int D_WIDTH  = ALU_D_WIDTH,
    parameter int OP_WIDTH = ALU_OP_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [OP_WIDTH-1:0] req0_op,
    input  logic [D_WIDTH-1:0]  req0_a,
    input  logic [D_WIDTH-1:0]  req0_b,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [OP_WIDTH-1:0] req1_op,
    input  logic [D_WIDTH-1:0]  req1_a,
    input  logic [D_WIDTH-1:0]  req1_b,
    output logic                rsp0_valid,
    input  logic                rsp0_ready,
    output logic [D_WIDTH-1:0]  rsp0_data,
    output logic                rsp0_zero,
    output logic                rsp1_valid,
    input  logic                rsp1_ready,
    output logic [D_WIDTH-1:0]  rsp1_data,
    output logic                rsp1_zero,
    output logic [OP_WIDTH-1:0] alu_operator,
    output logic [D_WIDTH-1:0]  alu_a,
    output logic [D_WIDTH-1:0]  alu_b,
    output logic                alu_rst_n,
    input  logic [D_WIDTH-1:0]  alu_c,
    input  logic                alu_zero
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [31:0]         stat_grant0,
    output logic [31:0]         stat_grant1,
    output logic [31:0]         stat_conflict
`endif
);

    port_e ptr;
    logic  free0, free1;
    logic  elig0, elig1;
    logic  grant0, grant1;

    assign alu_rst_n = ~rst;

    // Ready is forced low during reset so nothing is accepted on a reset edge.
    assign elig0 = req0_valid & free0 & ~rst;
    assign elig1 = req1_valid & free1 & ~rst;

    assign grant0 = elig0 & (~elig1 | (ptr == PORT0));
    assign grant1 = elig1 & (~elig0 | (ptr == PORT1));

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // NOTE: defaults first in always_comb so no path leaves an output unassigned
    // (no latch); idle cycles park the ALU on add 0,0.
    always_comb begin
        alu_operator = OP_WIDTH'(ALU_ADD);
        alu_a        = '0;
        alu_b        = '0;
        if (grant0) begin
            alu_operator = req0_op;
            alu_a        = req0_a;
            alu_b        = req0_b;
        end else if (grant1) begin
            alu_operator = req1_op;
            alu_a        = req1_a;
            alu_b        = req1_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= PORT0;
        end else if (grant0) begin
            ptr <= PORT1;
        end else if (grant1) begin
            ptr <= PORT0;
        end
    end

    alu_rsp_slot #(.D_WIDTH(D_WIDTH)) u_slot0 (
        .clk       (clk),
        .rst       (rst),
        .load      (grant0),
        .load_data (alu_c),
        .load_zero (alu_zero),
        .rsp_ready (rsp0_ready),
        .free      (free0),
        .rsp_valid (rsp0_valid),
        .rsp_data  (rsp0_data),
        .rsp_zero  (rsp0_zero)
    );

    alu_rsp_slot #(.D_WIDTH(D_WIDTH)) u_slot1 (
        .clk       (clk),
        .rst       (rst),
        .load      (grant1),
        .load_data (alu_c),
        .load_zero (alu_zero),
        .rsp_ready (rsp1_ready),
        .free      (free1),
        .rsp_valid (rsp1_valid),
        .rsp_data  (rsp1_data),
        .rsp_zero  (rsp1_zero)
    );

`ifdef ALU_ARB_STATS_EN
    // A conflict is a cycle with both requests valid where only one is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grant0   <= '0;
            stat_grant1   <= '0;
            stat_conflict <= '0;
        end else begin
            if (grant0) stat_grant0 <= stat_grant0 + 32'd1;
            if (grant1) stat_grant1 <= stat_grant1 + 32'd1;
            if (req0_valid & req1_valid & (grant0 | grant1))
                stat_conflict <= stat_conflict + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model. Define ALU_ARB_STATS_EN to cover counters.
module tb_alu_arbiter;

    localparam int D = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [3:0]    req0_op, req1_op;
    logic [D-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic          rsp0_valid, rsp1_valid;
    logic          rsp0_ready, rsp1_ready;
    logic [D-1:0]  rsp0_data, rsp1_data;
    logic          rsp0_zero, rsp1_zero;
    logic [3:0]    alu_operator;
    logic [D-1:0]  alu_a, alu_b, alu_c;
    logic          alu_rst_n, alu_zero;
`ifdef ALU_ARB_STATS_EN
    logic [31:0]   stat_grant0, stat_grant1, stat_conflict;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference-model state: what each requester should currently see.
    bit           m_valid[2];
    logic [D-1:0] m_data[2];
    bit           m_zero[2];
    int           prefer;
    logic [1:0]   g_obs;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_op      (req0_op),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_op      (req1_op),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .rsp0_valid   (rsp0_valid),
        .rsp0_ready   (rsp0_ready),
        .rsp0_data    (rsp0_data),
        .rsp0_zero    (rsp0_zero),
        .rsp1_valid   (rsp1_valid),
        .rsp1_ready   (rsp1_ready),
        .rsp1_data    (rsp1_data),
        .rsp1_zero    (rsp1_zero),
        .alu_operator (alu_operator),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_rst_n    (alu_rst_n),
        .alu_c        (alu_c),
        .alu_zero     (alu_zero)
`ifdef ALU_ARB_STATS_EN
        ,
        .stat_grant0  (stat_grant0),
        .stat_grant1  (stat_grant1),
        .stat_conflict(stat_conflict)
`endif
    );

    // RV32-style ALU semantics; unused codes return 0.
    function automatic logic [D-1:0] alu_ref(logic [3:0] op, logic [D-1:0] a, logic [D-1:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << b[4:0];
            4'd3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4:    return (a < b) ? 32'd1 : 32'd0;
            4'd5:    return a ^ b;
            4'd6:    return a >> b[4:0];
            4'd7:    return D'($signed(a) >>> b[4:0]);
            4'd8:    return a | b;
            4'd9:    return a & b;
            default: return '0;
        endcase
    endfunction

    always_comb begin
        alu_c    = alu_ref(alu_operator, alu_a, alu_b);
        alu_zero = (alu_c == '0);
    end

    task automatic check(string tag, logic [D-1:0] obs, logic [D-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(int k, logic v, logic [3:0] op, logic [D-1:0] a, logic [D-1:0] b);
        if (k == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    // One clock: check combinational grant/ALU drive, then the registered responses.
    task automatic step();
        logic [1:0]   rv, rr, elig, gnt;
        logic [3:0]   op[2];
        logic [D-1:0] a[2], b[2];
        logic [3:0]   e_op;
        logic [D-1:0] e_a, e_b;
        @(negedge clk);
        rv = {req1_valid, req0_valid};
        rr = {rsp1_ready, rsp0_ready};
        op[0] = req0_op; a[0] = req0_a; b[0] = req0_b;
        op[1] = req1_op; a[1] = req1_a; b[1] = req1_b;
        for (int k = 0; k < 2; k++)
            elig[k] = !rst && rv[k] && (!m_valid[k] || rr[k]);
        gnt = 2'b00;
        if (elig == 2'b11) gnt[prefer] = 1'b1;
        else               gnt = elig;
        g_obs = {req1_ready, req0_ready};
        check("req_ready", D'(g_obs), D'(gnt));
        e_op = 4'd0; e_a = '0; e_b = '0;
        for (int k = 0; k < 2; k++)
            if (gnt[k]) begin e_op = op[k]; e_a = a[k]; e_b = b[k]; end
        check("alu_operator", D'(alu_operator), D'(e_op));
        check("alu_a", alu_a, e_a);
        check("alu_b", alu_b, e_b);
        check("alu_rst_n", D'(alu_rst_n), D'(!rst));
        @(posedge clk);
        #1;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin m_valid[k] = 0; m_data[k] = '0; m_zero[k] = 0; end
            prefer = 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (gnt[k]) begin
                    m_valid[k] = 1;
                    m_data[k]  = alu_ref(op[k], a[k], b[k]);
                    m_zero[k]  = (m_data[k] == '0);
                end else if (rr[k]) begin
                    m_valid[k] = 0;
                end
            end
            if (gnt != 2'b00) prefer = gnt[0] ? 1 : 0;
        end
        check("rsp0_valid", D'(rsp0_valid), D'(m_valid[0]));
        check("rsp0_data",  rsp0_data,       m_data[0]);
        check("rsp0_zero",  D'(rsp0_zero),  D'(m_zero[0]));
        check("rsp1_valid", D'(rsp1_valid), D'(m_valid[1]));
        check("rsp1_data",  rsp1_data,       m_data[1]);
        check("rsp1_zero",  D'(rsp1_zero),  D'(m_zero[1]));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [D-1:0] ra;
        for (int k = 0; k < 2; k++) begin m_valid[k] = 0; m_data[k] = '0; m_zero[k] = 0; end
        prefer = 0;
        rst = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        set_req(0, 1'b1, 4'd0, 32'd1, 32'd2);
        set_req(1, 1'b1, 4'd0, 32'd3, 32'd4);

        // Reset with both requests pending: no ready, responses cleared.
        step();
        check("rst_no_ready", D'(g_obs), '0);
        step();
        check("rst_rsp0_valid", D'(rsp0_valid), '0);
        check("rst_rsp0_data", rsp0_data, '0);
        rst = 1'b0;

        // Single request on port 0: add 5+7.
        set_req(0, 1'b1, 4'd0, 32'd5, 32'd7);
        set_req(1, 1'b0, 4'd0, '0, '0);
        step();
        check("single_ready0", D'(g_obs), 32'd1);
        check("single_data", rsp0_data, 32'd12);
        check("single_zero", D'(rsp0_zero), '0);
        check("single_valid", D'(rsp0_valid), 32'd1);

        // Round-robin under conflict, starting from port 0 after reset.
        set_req(0, 1'b0, 4'd0, '0, '0);
        do_reset();
        set_req(0, 1'b1, 4'd0, 32'd1, 32'd1);
        set_req(1, 1'b1, 4'd1, 32'd9, 32'd9);
        step(); check("rr_g0", D'(g_obs), 32'd1);
        step(); check("rr_g1", D'(g_obs), 32'd2);
        check("sub_data", rsp1_data, '0);
        check("sub_zero", D'(rsp1_zero), 32'd1);
        step(); check("rr_g2", D'(g_obs), 32'd1);
        step(); check("rr_g3", D'(g_obs), 32'd2);

        // Backpressure on port 0, then same-cycle drain and refill.
        set_req(1, 1'b0, 4'd0, '0, '0);
        rsp0_ready = 1'b0;
        set_req(0, 1'b1, 4'd0, 32'd1, 32'd2);
        step();
        check("bp_fill", rsp0_data, 32'd3);
        set_req(0, 1'b1, 4'd0, 32'd10, 32'd20);
        set_req(1, 1'b1, 4'd5, 32'hF0, 32'h0F);
        step();
        check("bp_grant1", D'(g_obs), 32'd2);
        check("bp_hold", rsp0_data, 32'd3);
        rsp0_ready = 1'b1;
        set_req(1, 1'b0, 4'd0, '0, '0);
        step();
        check("refill_ready", D'(g_obs), 32'd1);
        check("refill_valid", D'(rsp0_valid), 32'd1);
        check("refill_data", rsp0_data, 32'd30);

        // Signed versus unsigned compare on port 1.
        set_req(0, 1'b0, 4'd0, '0, '0);
        set_req(1, 1'b1, 4'd3, 32'hFFFF_FFFF, 32'd1);
        step();
        check("slt", rsp1_data, 32'd1);
        set_req(1, 1'b1, 4'd4, 32'hFFFF_FFFF, 32'd1);
        step();
        check("sltu", rsp1_data, '0);

        // Unused operator code.
        set_req(1, 1'b0, 4'd0, '0, '0);
        set_req(0, 1'b1, 4'd15, 32'd3, 32'd4);
        step();
        check("bad_op_data", rsp0_data, '0);
        check("bad_op_zero", D'(rsp0_zero), 32'd1);

        // Reset while a response is held and both requests are pending.
        rsp0_ready = 1'b0;
        set_req(0, 1'b1, 4'd0, 32'd2, 32'd2);
        set_req(1, 1'b0, 4'd0, '0, '0);
        step();
        check("pre_rst_valid", D'(rsp0_valid), 32'd1);
        rsp0_ready = 1'b1;
        set_req(1, 1'b1, 4'd0, 32'd6, 32'd6);
        rst = 1'b1;
        step();
        check("mid_rst_ready", D'(g_obs), '0);
        check("mid_rst_v0", D'(rsp0_valid), '0);
        check("mid_rst_v1", D'(rsp1_valid), '0);
        rst = 1'b0;
        step();
        check("post_rst_first", D'(g_obs), 32'd1);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 39) == 0);
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 2) != 0);
            for (int k = 0; k < 2; k++) begin
                ra = $urandom;
                set_req(k, ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), ra,
                        ($urandom_range(0, 3) == 0) ? ra : D'($urandom));
            end
            step();
        end
        rst = 1'b0;

`ifdef ALU_ARB_STATS_EN
        // Ten conflict cycles split evenly between the ports.
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        do_reset();
        set_req(0, 1'b1, 4'd0, 32'd1, 32'd2);
        set_req(1, 1'b1, 4'd8, 32'd4, 32'd1);
        for (int i = 0; i < 10; i++) step();
        check("stat_conflict", stat_conflict, 32'd10);
        check("stat_grant0", stat_grant0, 32'd5);
        check("stat_grant1", stat_grant1, 32'd5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU between two requesters: port 0 is the execute stage and port 1 is the address/branch unit.
- Each request port has a valid/ready handshake. Each response port has a single-entry holding register with valid/ready.
- Round-robin arbitration. At most one ALU operation issues per cycle, and its result is registered.
- Sits between the pipeline stages and the ALU instance. It drives the ALU's operator/a/b/rst_n and samples c/zero.

Parameters:
- D_WIDTH, 32, operand and result width.
- OP_WIDTH, 4, operator code width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid / req1_valid  input  1  request present.
- req0_ready / req1_ready  output  1  request accepted this cycle.
- req0_op / req1_op  input  OP_WIDTH  ALU operator code (0000 add … 1001 and).
- req0_a, req0_b / req1_a, req1_b  input  D_WIDTH  operands.
- rsp0_valid / rsp1_valid  output  1  result held for requester.
- rsp0_ready / rsp1_ready  input  1  requester consumes result.
- rsp0_data / rsp1_data  output  D_WIDTH  registered ALU result.
- rsp0_zero / rsp1_zero  output  1  registered ALU zero flag.
- alu_operator  output  OP_WIDTH  to ALU operator.
- alu_a, alu_b  output  D_WIDTH  to ALU operands.
- alu_rst_n  output  1  to ALU reset; equals ~rst, combinational.
- alu_c  input  D_WIDTH  ALU result.
- alu_zero  input  1  ALU zero flag.

Behaviour:
- Reset (rst=1 at an edge):
  - rsp*_valid=0, rsp*_data=0, rsp*_zero=0.
  - Priority pointer set to port 0 (port 0 wins the first tie).
  - req*_ready=0 while rst is high.
- Eligibility: port k is eligible when reqk_valid=1 and (rspk_valid=0 or rspk_ready=1). A slot that is draining this cycle may refill in the same cycle.
- Arbitration (combinational):
  - If exactly one port is eligible, it is granted.
  - If both are eligible, the port named by the pointer is granted.
  - reqk_ready = grant_k. At most one ready is high per cycle.
- Pointer: after any grant, the pointer moves to the non-granted port. With no grant, it holds.
- ALU drive:
  - alu_operator/a/b = granted port's op/a/b.
  - When there is no grant, drive op 0000 with a=b=0 so the ALU inputs do not toggle.
- Result capture:
  - On a grant edge, rspk_data<=alu_c, rspk_zero<=alu_zero, rspk_valid<=1.
  - Latency is one cycle: the request is accepted at edge N and the response is visible from edge N until consumed.
- Response drain: at an edge with rspk_valid & rspk_ready and no new grant to k, rspk_valid<=0. Data holds its last value.
- Simultaneous drain and refill on port k: valid stays 1 and data updates to the new result.
- Response hold: while rspk_valid=1 and rspk_ready=0, data and zero are stable.
- Operator codes: unused operator codes (1010–1111) pass through unchanged. The ALU returns 0 for them, so rsp_zero=1.
- Reset mid-operation: in-flight results are discarded and the pointer returns to port 0. No response is produced for a request accepted in the same cycle as rst=1, because ready is forced low.
- Ordering: per port, responses are returned in acceptance order (single-entry slot).

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- When defined, add outputs stat_grant0, stat_grant1, stat_conflict (each 32-bit):
  - stat_grant0 / stat_grant1 count grants per port.
  - stat_conflict counts cycles where both ports are valid and one of them loses.
  - All counters wrap modulo 2^32 and clear on rst.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - localparams for operator codes: ALU_ADD=0000, ALU_SUB=0001, ALU_SLL=0010, ALU_SLT=0011, ALU_SLTU=0100, ALU_XOR=0101, ALU_SRL=0110, ALU_SRA=0111, ALU_OR=1000, ALU_AND=1001.
  - D_WIDTH/OP_WIDTH defaults.
- One sub-module: alu_rsp_slot, the single-entry valid/ready holding register with data+zero. It is instantiated twice.
- Arbitration logic and pointer stay in the top module.

Test Plan:
- Single request: req0 add a=5, b=7 → req0_ready=1 that cycle; next cycle rsp0_valid=1, rsp0_data=12, rsp0_zero=0.
- Conflict round-robin: both valid every cycle, rsp ready held 1 → grants alternate 0,1,0,1 starting with port 0 after reset. Port 1 sub a=9, b=9 gives rsp1_data=0, rsp1_zero=1.
- Backpressure:
  - rsp0_ready=0 with rsp0_valid=1 and req0_valid=1 → req0_ready=0 and port 1 is granted if valid; rsp0_data is stable.
  - Raising rsp0_ready → same-cycle refill, rsp0_valid stays 1 with the new data.
- Signed ops: port 1 slt a=0xFFFFFFFF, b=1 → rsp1_data=1; sltu with the same operands → rsp1_data=0.
- Reset mid-operation: assert rst while rsp0_valid=1 and both requests valid → after the edge rsp0/1_valid=0, no ready during rst, first grant after rst goes to port 0.
- Invalid opcode 1111 with a=3, b=4 → rsp_data=0, rsp_zero=1. Under ALU_ARB_STATS_EN, 10 conflict cycles → stat_conflict=10, stat_grant0=5, stat_grant1=5.
